// File: rtl/button_pkg.sv
// button_pkg: shared defaults, button indices and auto-repeat state for the button conditioner.
package button_pkg;
    localparam int DEBOUNCE_TICKS_DEFAULT = 2;
    localparam int REPEAT_DELAY_DEFAULT = 50;
    localparam int REPEAT_PERIOD_DEFAULT = 10;
    localparam int NUM_BUTTONS = 5;
    localparam int BTN_LEFT = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP = 2;
    localparam int BTN_DOWN = 3;
    localparam int BTN_CENTER = 4;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} repeat_state_t;
endpackage

// File: rtl/button_channel.sv
// button_channel: synchronizer, debouncer, press-pulse generator and optional auto-repeat for one button.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic clk_core,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic level
);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(RMAX + 1);
    logic sync1, sync2, stable, flip, rise, fall, fire;
    logic [DW-1:0] cnt;
    logic [HW-1:0] hcnt;
    repeat_state_t state, state_next;
    assign flip = (sync2 != stable) && (cnt == DW'(DEBOUNCE_TICKS - 1));
    assign rise = flip && sync2;
    assign fall = flip && !sync2;
    assign level = stable;
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            stable <= 1'b0;
            cnt <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            stable <= flip ? sync2 : stable;
            cnt <= (sync2 != stable && !flip) ? cnt + DW'(1) : '0;
            pulse <= rise || fire;
        end
    end
    // hcnt counts edges since the press (HOLD) or since the last repeat (REPEAT)
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hcnt <= '0;
        end else begin
            state <= state_next;
            hcnt <= (state == IDLE || fire || fall) ? '0 : hcnt + HW'(1);
        end
    end
    always_comb begin
        state_next = fall ? IDLE
                   : (state == IDLE && rise && REPEAT_EN) ? HOLD
                   : fire ? REPEAT
                   : state;
    end
    always_comb begin
        fire = !fall && ((state == HOLD && hcnt == HW'(REPEAT_DELAY - 1))
                      || (state == REPEAT && hcnt == HW'(REPEAT_PERIOD - 1)));
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: five conditioned push-buttons with up/down auto-repeat and
// fixed-priority arbitration so at most one directional pulse is issued per cycle.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk_core,
    input  logic rst_n,
    input  logic left_raw,
    input  logic right_raw,
    input  logic up_raw,
    input  logic down_raw,
    input  logic center_raw,
    output logic left_button,
    output logic right_button,
    output logic up_button,
    output logic down_button,
    output logic center_button,
    output logic right_level
);
    logic [NUM_BUTTONS-1:0] raw, pulse, lvl;
    logic unused;
    assign raw[BTN_LEFT] = left_raw;
    assign raw[BTN_RIGHT] = right_raw;
    assign raw[BTN_UP] = up_raw;
    assign raw[BTN_DOWN] = down_raw;
    assign raw[BTN_CENTER] = center_raw;
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN(i == BTN_UP || i == BTN_DOWN)
        ) u_ch (
            .clk_core(clk_core),
            .rst_n(rst_n),
            .raw(raw[i]),
            .pulse(pulse[i]),
            .level(lvl[i])
        );
    end
    // left > right > up > down; losing pulses are dropped
    assign left_button = pulse[BTN_LEFT];
    assign right_button = pulse[BTN_RIGHT] && !pulse[BTN_LEFT];
    assign up_button = pulse[BTN_UP] && !pulse[BTN_LEFT] && !pulse[BTN_RIGHT];
    assign down_button = pulse[BTN_DOWN] && !(pulse[BTN_LEFT] || pulse[BTN_RIGHT] || pulse[BTN_UP]);
    assign center_button = pulse[BTN_CENTER];
    assign right_level = lvl[BTN_RIGHT];
    assign unused = ^{lvl[BTN_LEFT], lvl[BTN_UP], lvl[BTN_DOWN], lvl[BTN_CENTER]};
endmodule
